// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: grants one of NUM_REQ requesters per cycle into a
// single registered output stage that drives a one-hot register-file write enable.
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rf_stall,
    output logic [31:0]               rf_we,
    output logic [4:0]                rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      out_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: requester i transfers in any cycle where req_valid[i] && req_ready[i];
    // it must hold valid/addr/data stable until then. req_ready is low whenever the
    // output stage is held by rf_stall or reset is asserted.

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              out_valid_q, out_valid_d;

    logic              stage_free;
    logic              found;
    logic [PTR_W:0]    scan_sum;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [4:0]        addr_sel;
    logic [DATA_W-1:0] data_sel;

    assign stage_free = !out_valid_q || !rf_stall;

    // Scan upward from rr_ptr, wrapping modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (stage_free && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                    scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
                end
                scan_idx = scan_sum[PTR_W-1:0];
                if (!found && req_valid[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                addr_sel = req_addr[5*i +: 5];
                data_sel = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        out_valid_d = out_valid_q;
        if (found) begin
            rf_waddr_d  = addr_sel;
            rf_wdata_d  = data_sel;
            out_valid_d = 1'b1;
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Register 0 is hardwired: accepted like any write but never enabled.
    assign rf_we     = (out_valid_q && (rf_waddr_q != 5'd0)) ? (32'd1 << rf_waddr_q) : 32'd0;
    assign req_ready = grant;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single write, round-robin order,
// stall hold with back-to-back release, register zero, reset mid-stall, sparse fairness.
module tb_wb_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [5*NUM_REQ-1:0]      req_addr;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_stall;
    logic [31:0]               rf_we;
    logic [4:0]                rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      out_valid;

    int n_checks;
    int n_fail;

    wb_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then changed at posedge+1 and checked at posedge+2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rf_stall  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_addr  = '0;
        req_data  = '0;
        reset     = 1'b1;
        rf_stall  = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || rf_we !== 32'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs: ov=%b we=%h wa=%0d wd=%h want 0", out_valid, rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (dut.rr_ptr_q !== 2'd0) begin
            n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr_q);
        end
        req_valid = '0;
        reset     = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_addr[4:0]  = 5'd5;
        req_data[31:0] = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (rf_we !== 32'h0000_0020 || rf_wdata !== 32'hDEADBEEF || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_write: we=%h wd=%h ov=%b want 00000020 deadbeef 1", rf_we, rf_wdata, out_valid);
        end
        n_checks++;
        if (dut.rr_ptr_q !== 2'd1) begin
            n_fail++; $display("FAIL single_rr_ptr: got %0d want 1", dut.rr_ptr_q);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || rf_we !== 32'd0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_drain: ov=%b we=%h wa=%0d wd=%h want 0 0 5 deadbeef", out_valid, rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [1:0] exp_ptr;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[5*i +: 5]            = 5'(i + 1);
            req_data[DATA_W*i +: DATA_W]  = 32'h100 + 32'(i);
        end
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_ready = 4'b0001 << (j % 4);
            exp_ptr   = 2'((j + 1) % 4);
            #1;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", j, req_ready, exp_ready);
            end
            step();
            #1;
            n_checks++;
            if (dut.rr_ptr_q !== exp_ptr || rf_waddr !== 5'((j % 4) + 1) || rf_wdata !== 32'h100 + 32'(j % 4)) begin
                n_fail++; $display("FAIL rr_load[%0d]: ptr=%0d wa=%0d wd=%h want %0d %0d %h", j, dut.rr_ptr_q, rf_waddr, rf_wdata, exp_ptr, (j % 4) + 1, 32'h100 + 32'(j % 4));
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall_back_to_back();
        do_reset();
        req_valid = 4'b0001;
        req_addr[4:0] = 5'd7;
        req_data[31:0] = 32'h7777_0000;
        step();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[5*i +: 5] = 5'(10 + i);
            req_data[DATA_W*i +: DATA_W] = 32'hA0 + 32'(i);
        end
        rf_stall  = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || rf_we !== 32'h0000_0080 || out_valid !== 1'b1 || dut.rr_ptr_q !== 2'd1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: ready=%b we=%h ov=%b ptr=%0d want 0000 00000080 1 1", c, req_ready, rf_we, out_valid, dut.rr_ptr_q);
            end
            step();
        end
        rf_stall = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010 || rf_we !== 32'h0000_0080) begin
            n_fail++; $display("FAIL stall_release: ready=%b we=%h want 0010 00000080", req_ready, rf_we);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (rf_waddr !== 5'd11 || rf_wdata !== 32'hA1 || rf_we !== 32'h0000_0800 || out_valid !== 1'b1 || dut.rr_ptr_q !== 2'd2) begin
            n_fail++; $display("FAIL back_to_back: wa=%0d wd=%h we=%h ov=%b ptr=%0d want 11 a1 00000800 1 2", rf_waddr, rf_wdata, rf_we, out_valid, dut.rr_ptr_q);
        end
        step();
    endtask

    task automatic test_reg_zero();
        do_reset();
        req_valid = 4'b0100;
        req_addr[14:10] = 5'd0;
        req_data[95:64] = 32'h55;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL zero_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || rf_we !== 32'd0 || rf_waddr !== 5'd0 || dut.rr_ptr_q !== 2'd3) begin
            n_fail++; $display("FAIL zero_write: ov=%b we=%h wa=%0d ptr=%0d want 1 0 0 3", out_valid, rf_we, rf_waddr, dut.rr_ptr_q);
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        req_valid = 4'b0001;
        req_addr[4:0] = 5'd9;
        step();
        rf_stall  = 1'b1;
        req_valid = '0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || rf_we !== 32'h0000_0200) begin
            n_fail++; $display("FAIL midstall_pre: ov=%b we=%h want 1 00000200", out_valid, rf_we);
        end
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midstall_ready: got %b want 0000", req_ready);
        end
        step();
        reset     = 1'b0;
        req_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || rf_we !== 32'd0 || dut.rr_ptr_q !== 2'd0 || rf_waddr !== 5'd0) begin
            n_fail++; $display("FAIL midstall_after: ov=%b we=%h ptr=%0d wa=%0d want 0 0 0 0", out_valid, rf_we, dut.rr_ptr_q, rf_waddr);
        end
        step();
        n_checks++;
        if (rf_we !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midstall_discard: ov=%b we=%h want 0 0", out_valid, rf_we);
        end
        rf_stall = 1'b0;
    endtask

    task automatic test_sparse_fairness();
        logic [3:0] exp_ready [4];
        logic [1:0] exp_ptr   [4];
        exp_ready = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        exp_ptr   = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        req_valid = 4'b0010;
        step();
        n_checks++;
        if (dut.rr_ptr_q !== 2'd2) begin
            n_fail++; $display("FAIL sparse_setup: ptr=%0d want 2", dut.rr_ptr_q);
        end
        req_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_checks++;
            if (req_ready !== exp_ready[j]) begin
                n_fail++; $display("FAIL sparse_grant[%0d]: got %b want %b", j, req_ready, exp_ready[j]);
            end
            step();
            n_checks++;
            if (dut.rr_ptr_q !== exp_ptr[j]) begin
                n_fail++; $display("FAIL sparse_ptr[%0d]: got %0d want %0d", j, dut.rr_ptr_q, exp_ptr[j]);
            end
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        rf_stall  = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall_back_to_back();
        test_reg_zero();
        test_reset_mid_stall();
        test_sparse_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
